// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-cycle multi-precision adder/subtractor.
// One 8-bit limb is added per cycle, LSB limb first, and the carry is chained
// through a register. Subtraction is performed as A + ~B + ~bin.
module wide_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*WORDS-1:0]   a,
    input  logic [8*WORDS-1:0]   b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);

    localparam int unsigned W  = 8 * WORDS;
    localparam int unsigned CW = $clog2(WORDS) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [7:0]      a_limb;
    logic [7:0]      b_limb;
    logic [8:0]      limb_sum;
    logic            last_limb;

    // Limb adder: select the current limb of each operand and add with carry.
    always_comb begin
        a_limb = '0;
        b_limb = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (cnt_q == CW'(i)) begin
                a_limb = a_q[8*i +: 8];
                b_limb = b_q[8*i +: 8];
            end
        end
        limb_sum  = {1'b0, a_limb} + {1'b0, b_limb} + {8'b0, carry_q};
        last_limb = (cnt_q == CW'(WORDS - 1));
    end

    // Next-state logic: accept in IDLE, one limb per cycle in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {W{sub}};
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int unsigned i = 0; i < WORDS; i++) begin
                    if (cnt_q == CW'(i)) begin
                        sum_d[8*i +: 8] = limb_sum[7:0];
                    end
                end
                carry_d = limb_sum[8];
                cnt_d   = cnt_q + 1'b1;
                if (last_limb) begin
                    cout_d  = limb_sum[8];
                    // carry into bit 7 is a^b^s at bit 7; overflow is that xor carry out
                    ovf_d   = a_limb[7] ^ b_limb[7] ^ limb_sum[7] ^ limb_sum[8];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Output decode.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Testbench for wide_add_seq with WORDS=4: directed and random operations
// compared against an arithmetic reference model.
module tb_wide_add_seq;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, cout, sum} from plain wide unsigned/signed arithmetic.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rcin, input logic rsub);
        longint unsigned ua, ub, full;
        longint          sa, sb, sres;
        logic            c, o;
        ua = longint'(ra);
        ub = longint'(rb);
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        if (!rsub) begin
            full = ua + ub + longint'(rcin);
            c    = (full >= (64'd1 << W));
            sres = sa + sb + longint'(rcin);
        end else begin
            full = ua - ub - longint'(rcin);
            c    = (ua >= ub + longint'(rcin));
            sres = sa - sb - longint'(rcin);
        end
        o = (sres > ((64'sd1 <<< (W-1)) - 1)) || (sres < -(64'sd1 <<< (W-1)));
        return {o, c, full[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation; hold = cycles of backpressure once the result is up.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                         input logic tsub, input int unsigned hold);
        logic [W+1:0] exp;
        exp = ref_op(ta, tb, tcin, tsub);
        @(negedge clk);
        check("in_ready_before", 64'(in_ready), 64'd1);
        a         = ta;
        b         = tb;
        cin       = tcin;
        sub       = tsub;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_after_accept", 64'({busy, in_ready, out_valid}), 64'b100);
        for (int k = 1; k <= int'(WORDS); k++) begin
            @(posedge clk);
            @(negedge clk);
            check("out_valid_latency", 64'(out_valid), 64'(k == int'(WORDS)));
        end
        check("sum", 64'(sum), 64'(exp[W-1:0]));
        check("cout", 64'(cout), 64'(exp[W]));
        check("ovf", 64'(ovf), 64'(exp[W+1]));
        for (int j = 0; j < int'(hold); j++) begin
            in_valid = 1'($urandom);
            a        = W'($urandom);
            b        = W'($urandom);
            sub      = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_ctrl", 64'({out_valid, in_ready, busy}), 64'b101);
            check("hold_result", 64'({ovf, cout, sum}), 64'(exp));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("after_handshake", 64'({out_valid, in_ready, busy}), 64'b010);
        check("result_kept", 64'({ovf, cout, sum}), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
        check("reset_result", 64'({ovf, cout, sum}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);

        // Directed corner cases
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        do_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 0);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
        do_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 0);
        do_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 0);

        // Long backpressure with new operands offered meanwhile
        do_op(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, 1'b0, 10);

        // Reset mid-RUN after two limbs
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_abort_busy", 64'({busy, out_valid}), 64'b10);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_ctrl", 64'({in_ready, out_valid, busy}), 64'b100);
        check("abort_result", 64'({ovf, cout, sum}), 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_no_valid", 64'(out_valid), 64'd0);
        end
        do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0);

        // Random operations with random backpressure
        for (int n = 0; n < 40; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
